// File: rtl/pc_unit_if.sv
// Fetch-PC control/status bundle between decode/execute/trap logic and the PC unit.
// Latency: none (wires only).
// Backpressure: stall_i from the consumer side freezes the PC.
interface pc_unit_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            trap_i;
    logic            call_i;
    logic [XLEN-1:0] call_target_i;
    logic            ret_i;
    logic [XLEN-1:0] ret_target_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            misalign_o;
    logic [CW-1:0]   ras_count_o;
    logic            ras_ovf_o;
    logic            ras_unf_o;

    // Control side: drives redirect/stall/call/ret, observes the fetch PC.
    modport master (
        output stall_i, redirect_i, redirect_pc_i, trap_i,
               call_i, call_target_i, ret_i, ret_target_i,
        input  pc_o, pc_valid_o, misalign_o, ras_count_o, ras_ovf_o, ras_unf_o
    );

    // PC unit side.
    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, trap_i,
               call_i, call_target_i, ret_i, ret_target_i,
        output pc_o, pc_valid_o, misalign_o, ras_count_o, ras_ovf_o, ras_unf_o
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with reset vector, stall, redirect, trap vectoring and a circular RAS.
// Latency: every PC change is visible one cycle after the sampling edge (registered pc_o).
// Backpressure: stall_i holds the PC and the RAS; trap_i and redirect_i override it.
module pc_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);
    localparam int              PW      = $clog2(RAS_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [XLEN-1:0] INC_X   = XLEN'(INC);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(RAS_DEPTH);

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
    logic              wr_en;
    logic [PW-1:0]     wr_ptr;
    logic [XLEN-1:0]   wr_dat;

    logic [XLEN-1:0]   pc_inc;

    // Unsigned modulo add: the top of the address space wraps silently to zero.
    assign pc_inc = pc_q + INC_X;

    // State, PC and RAS bookkeeping registers; reset returns to BOOT at RESET_VEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // RAS storage needs no reset: entries are only read when the count says they are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ras_mem[wr_ptr] <= wr_dat;
        end
    end

    // Next-state / next-PC selection; priority trap > redirect > stall > ret&call > ret > call > sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        wr_en   = 1'b0;
        wr_ptr  = ptr_q;
        wr_dat  = pc_inc;

        case (state_q)
            BOOT: begin
                // First edge out of reset only validates RESET_VEC; controls are ignored.
                state_d = RUN;
            end
            RUN: begin
                if (bus.trap_i) begin
                    pc_d  = TRAP_VEC;
                    cnt_d = '0;
                end else if (bus.redirect_i) begin
                    pc_d = bus.redirect_pc_i;
                end else if (bus.stall_i) begin
                    pc_d = pc_q;
                end else if (bus.ret_i && bus.call_i) begin
                    // Tail-call style: return address replaces the top instead of pop+push.
                    pc_d  = bus.call_target_i;
                    wr_en = 1'b1;
                    if (cnt_q == '0) begin
                        wr_ptr = ptr_q + PTR_ONE;
                        ptr_d  = ptr_q + PTR_ONE;
                        cnt_d  = CNT_ONE;
                        unf_d  = 1'b1;
                    end else begin
                        wr_ptr = ptr_q;
                    end
                end else if (bus.ret_i) begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_mem[ptr_q];
                        ptr_d = ptr_q - PTR_ONE;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        pc_d  = bus.ret_target_i;
                        unf_d = 1'b1;
                    end
                end else if (bus.call_i) begin
                    // When full, advancing the pointer lands on the oldest entry and overwrites it.
                    pc_d   = bus.call_target_i;
                    wr_en  = 1'b1;
                    wr_ptr = ptr_q + PTR_ONE;
                    ptr_d  = ptr_q + PTR_ONE;
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    pc_d = pc_inc;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.pc_o        = pc_q;
    assign bus.pc_valid_o  = (state_q == RUN);
    assign bus.misalign_o  = ((pc_q % INC_X) != '0);
    assign bus.ras_count_o = cnt_q;
    assign bus.ras_ovf_o   = ovf_q;
    assign bus.ras_unf_o   = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, stall/redirect/trap priority, RAS overflow/underflow, wrap, misalign.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: stall_i exercised directly.
module tb_pc_unit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    pc_unit_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

    pc_unit #(
        .XLEN(32),
        .RESET_VEC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100),
        .INC(4),
        .RAS_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.trap_i        = 1'b0;
        bus.call_i        = 1'b0;
        bus.ret_i         = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle();
        bus.redirect_pc_i = '0;
        bus.call_target_i = '0;
        bus.ret_target_i  = '0;

        // Reset state
        #12;
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_valid", 32'(bus.pc_valid_o), 32'h0);
        chk("rst_count", 32'(bus.ras_count_o), 32'h0);
        chk("rst_ovf", 32'(bus.ras_ovf_o), 32'h0);
        chk("rst_unf", 32'(bus.ras_unf_o), 32'h0);
        rst_n = 1'b1;
        step(); chk("boot_pc", bus.pc_o, 32'h0); chk("boot_valid", 32'(bus.pc_valid_o), 32'h1);
        step(); chk("seq1", bus.pc_o, 32'h4);
        step(); chk("seq2", bus.pc_o, 32'h8);

        // T1: async reset mid-run at 0x40
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h40;
        step(); chk("t1_at40", bus.pc_o, 32'h40);
        idle();
        #3 rst_n = 1'b0;
        #1;
        chk("t1_async_pc", bus.pc_o, 32'h0);
        chk("t1_async_valid", 32'(bus.pc_valid_o), 32'h0);
        rst_n = 1'b1;
        step(); chk("t1_e1_pc", bus.pc_o, 32'h0); chk("t1_e1_valid", 32'(bus.pc_valid_o), 32'h1);
        step(); chk("t1_e2", bus.pc_o, 32'h4);
        step(); chk("t1_e3", bus.pc_o, 32'h8);

        // T2: stall holds, redirect overrides stall
        step(); step(); chk("t2_at10", bus.pc_o, 32'h10);
        bus.stall_i = 1'b1;
        bus.call_i = 1'b1; bus.call_target_i = 32'h999;
        step(); chk("t2_stall1", bus.pc_o, 32'h10);
        step(); chk("t2_stall2", bus.pc_o, 32'h10);
        step(); chk("t2_stall3", bus.pc_o, 32'h10); chk("t2_stall_cnt", 32'(bus.ras_count_o), 32'h0);
        bus.call_i = 1'b0;
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h200;
        step(); chk("t2_redir", bus.pc_o, 32'h200);
        idle();

        // T3: trap beats everything and clears the RAS
        bus.call_i = 1'b1; bus.call_target_i = 32'h500;
        step(); chk("t3_call_pc", bus.pc_o, 32'h500); chk("t3_call_cnt", 32'(bus.ras_count_o), 32'h1);
        bus.trap_i = 1'b1; bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h777; bus.stall_i = 1'b1;
        step(); chk("t3_trap_pc", bus.pc_o, 32'h100); chk("t3_trap_cnt", 32'(bus.ras_count_o), 32'h0);
        idle();

        // T4: five calls overflow a 4-deep RAS, then unwind
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0;
        step(); chk("t4_at0", bus.pc_o, 32'h0);
        idle();
        bus.call_i = 1'b1;
        bus.call_target_i = 32'h20; step();
        bus.call_target_i = 32'h40; step();
        bus.call_target_i = 32'h60; step();
        bus.call_target_i = 32'h80; step();
        chk("t4_c4_cnt", 32'(bus.ras_count_o), 32'h4); chk("t4_c4_ovf", 32'(bus.ras_ovf_o), 32'h0);
        bus.call_target_i = 32'hA0; step();
        chk("t4_c5_pc", bus.pc_o, 32'hA0);
        chk("t4_c5_ovf", 32'(bus.ras_ovf_o), 32'h1);
        chk("t4_c5_cnt", 32'(bus.ras_count_o), 32'h4);
        idle();
        bus.ret_i = 1'b1;
        step(); chk("t4_r1", bus.pc_o, 32'h84); chk("t4_r1_ovf", 32'(bus.ras_ovf_o), 32'h0);
        chk("t4_r1_cnt", 32'(bus.ras_count_o), 32'h3);
        step(); chk("t4_r2", bus.pc_o, 32'h64);
        step(); chk("t4_r3", bus.pc_o, 32'h44);
        step(); chk("t4_r4", bus.pc_o, 32'h24); chk("t4_r4_cnt", 32'(bus.ras_count_o), 32'h0);
        chk("t4_r4_unf", 32'(bus.ras_unf_o), 32'h0);
        bus.ret_target_i = 32'h300;
        step(); chk("t4_r5", bus.pc_o, 32'h300); chk("t4_r5_unf", 32'(bus.ras_unf_o), 32'h1);
        idle();
        step(); chk("t4_after", bus.pc_o, 32'h304); chk("t4_unf_clr", 32'(bus.ras_unf_o), 32'h0);

        // T5: wrap and misalignment
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFC;
        step(); chk("t5_top", bus.pc_o, 32'hFFFF_FFFC);
        idle();
        step(); chk("t5_wrap", bus.pc_o, 32'h0); chk("t5_mis0", 32'(bus.misalign_o), 32'h0);
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h102;
        step(); chk("t5_mis_pc", bus.pc_o, 32'h102); chk("t5_mis1", 32'(bus.misalign_o), 32'h1);
        idle();
        step(); chk("t5_mis_seq", bus.pc_o, 32'h106); chk("t5_mis2", 32'(bus.misalign_o), 32'h1);

        // T6: ret&call replaces the top entry
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h8FC;
        step();
        idle();
        bus.call_i = 1'b1; bus.call_target_i = 32'h50;
        step(); chk("t6_at50", bus.pc_o, 32'h50); chk("t6_cnt1", 32'(bus.ras_count_o), 32'h1);
        bus.ret_i = 1'b1; bus.call_target_i = 32'h700;
        step(); chk("t6_rc_pc", bus.pc_o, 32'h700); chk("t6_rc_cnt", 32'(bus.ras_count_o), 32'h1);
        chk("t6_rc_unf", 32'(bus.ras_unf_o), 32'h0);
        idle();
        bus.ret_i = 1'b1;
        step(); chk("t6_ret", bus.pc_o, 32'h54); chk("t6_ret_cnt", 32'(bus.ras_count_o), 32'h0);
        // ret&call with an empty RAS pushes and flags underflow
        bus.call_i = 1'b1; bus.call_target_i = 32'h600;
        step(); chk("t6_e_pc", bus.pc_o, 32'h600); chk("t6_e_cnt", 32'(bus.ras_count_o), 32'h1);
        chk("t6_e_unf", 32'(bus.ras_unf_o), 32'h1);
        bus.call_i = 1'b0;
        step(); chk("t6_e_ret", bus.pc_o, 32'h58);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
